fir_inverse_decoder: RTL and testbench

//  Inverse (deconvolution) filter for the monic 4-tap FIR datapath: recovers x[n] from y[n].

---
 rtl/fir_inverse_decoder_if.sv | 30 +++
 rtl/fir_inverse_decoder.sv | 119 +++++++++++
 tb/tb_fir_inverse_decoder.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_inverse_decoder_if.sv
// Stream bundle for the FIR inverse decoder.
// Carries both input (y) and output (x) valid/ready channels.
interface fir_inverse_decoder_if #(
  parameter int SIZE = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] y_in;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] x_out;

  modport master (
    output in_valid,
    output y_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  x_out
  );

  modport slave (
    input  in_valid,
    input  y_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output x_out
  );
endinterface

// File: rtl/fir_inverse_decoder.sv
// Inverse FIR: x[n] = y[n] - sum h[k]*x[n-k], mod 2^SIZE, one MAC per clock.
// Optional macro FIR_DEC_FLUSH_EN adds a flush port that clears history.
module fir_inverse_decoder #(
  parameter int SIZE      = 8,
  parameter int NUM_COEFF = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SIZE*NUM_COEFF-1:0] coeffs,
  fir_inverse_decoder_if.slave      bus,
  output logic                      busy
`ifdef FIR_DEC_FLUSH_EN
  ,
  input  logic                      flush
`endif
);

  localparam int HD = (NUM_COEFF > 1) ? NUM_COEFF - 1 : 1;
  localparam int KW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SIZE-1:0]    r_acc;
  logic [KW-1:0]      r_k;
  logic [HD*SIZE-1:0] r_hist;

  logic               w_clr;
  logic [KW-1:0]      w_hidx;
  logic [SIZE-1:0]    w_h;
  logic [SIZE-1:0]    w_hs;
  logic [2*SIZE-1:0]  w_prod;
  logic [SIZE-1:0]    w_acc_mac;

`ifdef FIR_DEC_FLUSH_EN
  assign w_clr = flush;
`else
  assign w_clr = 1'b0;
`endif

  assign w_hidx    = r_k - KW'(1);
  assign w_h       = coeffs[r_k*SIZE +: SIZE];
  assign w_hs      = r_hist[w_hidx*SIZE +: SIZE];
  assign w_prod    = {{SIZE{1'b0}}, w_h} * {{SIZE{1'b0}}, w_hs};
  assign w_acc_mac = r_acc - w_prod[SIZE-1:0];

  assign busy = (r_state != S_IDLE);

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.x_out     = '0;
    unique case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid)
          w_state_nxt = (NUM_COEFF > 1) ? S_MAC : S_OUT;
      end
      S_MAC: begin
        if (r_k == KW'(NUM_COEFF - 1))
          w_state_nxt = S_OUT;
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        bus.x_out     = r_acc;
        if (bus.out_ready)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset and flush both return to IDLE
  always_ff @(posedge clk) begin
    if (reset || w_clr)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Accumulator, tap index and sample history
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_acc  <= '0;
      r_k    <= '0;
      r_hist <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_acc <= bus.y_in;
            r_k   <= KW'(1);
          end
        end
        S_MAC: begin
          r_acc <= w_acc_mac;
          r_k   <= r_k + KW'(1);
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_hist <= (r_hist << SIZE) | (HD*SIZE)'(r_acc);
            r_k    <= '0;
          end
        end
        default: begin
          r_k <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_inverse_decoder.sv
// Testbench for fir_inverse_decoder with a reference recursion model.
// Expected samples are queued at accept time and compared at output.
module tb_fir_inverse_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] coeffs;
  logic        busy;
  logic        flush;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0] m_hist [3];
  logic [7:0] s_y [8];
  logic [7:0] sb_q [$];
  logic [7:0] got_q [$];
  int         lat_q [$];
  int         acc_q [$];

  fir_inverse_decoder_if #(.SIZE(8)) bus ();

  fir_inverse_decoder #(
    .SIZE(8),
    .NUM_COEFF(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coeffs(coeffs),
    .bus(bus),
    .busy(busy)
`ifdef FIR_DEC_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: cyc=%0d required finish", cyc);
    $fatal(1);
  end

  function automatic logic [7:0] model_step(input logic [7:0] y);
    logic [7:0]  x;
    logic [15:0] p;
    x = y;
    for (int k = 1; k < 4; k++) begin
      p = 16'(coeffs[8*k +: 8]) * 16'(m_hist[k-1]);
      x = x - p[7:0];
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = x;
    return x;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 3; i++) m_hist[i] = 8'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_clear();
  endtask

  task automatic run_stream(input int n, input int budget);
    int idx;
    int outs;
    int pend [$];
    idx = 0;
    outs = 0;
    got_q.delete();
    lat_q.delete();
    acc_q.delete();
    for (int c = 0; c < budget && outs < n; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.x_out);
        if (pend.size() > 0) lat_q.push_back(cyc - pend.pop_front());
        else lat_q.push_back(-1);
        outs++;
      end
      if (idx < n) begin
        bus.in_valid = 1'b1;
        bus.y_in = s_y[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(model_step(bus.y_in));
        pend.push_back(cyc + 1);
        acc_q.push_back(cyc + 1);
        idx++;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.x_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_x_out: got %0d want 0", bus.x_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_impulse();
    logic [7:0] spec [4];
    logic [7:0] e;
    logic [7:0] g;
    spec = '{8'd5, 8'd0, 8'd0, 8'd0};
    s_y[0] = 8'd5; s_y[1] = 8'd10; s_y[2] = 8'd15; s_y[3] = 8'd20;
    run_stream(4, 100);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL impulse_count: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e || g !== spec[i]) begin
        errors++;
        $display("FAIL impulse_x[%0d]: got %0d want %0d", i, g, spec[i]);
      end
      checks++;
      if (lat_q[i] != 3) begin
        errors++;
        $display("FAIL impulse_latency[%0d]: got %0d want 3", i, lat_q[i]);
      end
    end
    sb_q.delete();
  endtask

  task automatic test_wrap();
    logic [7:0] g;
    logic [7:0] e;
    s_y[0] = 8'd100; s_y[1] = 8'd44;
    run_stream(2, 60);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 2", got_q.size());
    end
    for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e || g !== 8'd100) begin
        errors++;
        $display("FAIL wrap_x[%0d]: got %0d want 100", i, g);
      end
    end
    sb_q.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] x0;
    logic [7:0] e;
    int c;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.y_in = 8'd33;
    c = 0;
    while (!bus.in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    sb_q.push_back(model_step(8'd33));
    @(negedge clk);
    bus.y_in = 8'd77;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_busy: got %b want 1", busy);
    end
    c = 0;
    while (!bus.out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_out_valid_timeout: got %b want 1", bus.out_valid);
    end
    x0 = bus.x_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.x_out !== x0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %0d/%b want %0d/1", i, bus.x_out, bus.out_valid, x0);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    e = sb_q.pop_front();
    checks++;
    if (bus.x_out !== e) begin
      errors++;
      $display("FAIL bp_x: got %0d want %0d", bus.x_out, e);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ov=%b ir=%b busy=%b want 0 1 0", bus.out_valid, bus.in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_mac();
    int seen;
    logic [7:0] e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.y_in = 8'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mac_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_mac_out_valid: got %0d pulses want 0", seen);
    end
    s_y[0] = 8'd9;
    run_stream(1, 40);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL rst_mac_count: got %0d want 1", got_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (got_q[0] !== e || got_q[0] !== 8'd9) begin
        errors++;
        $display("FAIL rst_mac_x: got %0d want 9", got_q[0]);
      end
    end
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [7:0] g;
    do_reset();
    s_y[0] = 8'd1; s_y[1] = 8'd3; s_y[2] = 8'd6; s_y[3] = 8'd10;
    run_stream(4, 100);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      e = sb_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e || g !== 8'd1) begin
        errors++;
        $display("FAIL b2b_x[%0d]: got %0d want 1", i, g);
      end
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] - acc_q[i-1] != 5) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 5", i, acc_q[i] - acc_q[i-1]);
      end
    end
    sb_q.delete();
  endtask

`ifdef FIR_DEC_FLUSH_EN
  task automatic test_flush();
    logic [7:0] e;
    do_reset();
    s_y[0] = 8'd5;
    run_stream(1, 40);
    e = sb_q.pop_front();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== e) begin
      errors++;
      $display("FAIL flush_first: got %0d outputs want 1 of value %0d", got_q.size(), e);
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_clear();
    s_y[0] = 8'd10;
    run_stream(1, 40);
    e = sb_q.pop_front();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== e || got_q[0] !== 8'd10) begin
      errors++;
      $display("FAIL flush_x: got %0d outputs, first %0d want 10", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'd0);
    end
    sb_q.delete();
  endtask
`endif

  initial begin
    coeffs = {8'd4, 8'd3, 8'd2, 8'd1};
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.y_in = 8'd0;
    bus.out_ready = 1'b1;
    m_clear();
    test_reset();
    test_impulse();
    test_wrap();
    test_backpressure();
    test_reset_mid_mac();
    test_back_to_back();
`ifdef FIR_DEC_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
